// File: rtl/frac_prod_normalizer_pkg.sv
// frac_prod_normalizer_pkg: shared constants, state encoding and width helper
package frac_prod_normalizer_pkg;
   localparam int FRAC_W_DEF = 7;
   localparam int PROD_W_DEF = 2 * FRAC_W_DEF;
   typedef enum logic {IDLE, NORM} state_t;
   function automatic int prod_w(input int frac_w);
      return 2 * frac_w;
   endfunction
endpackage

// File: rtl/frac_rne_round.sv
// frac_rne_round: round a normalized product to FRAC_W bits, nearest-even, with overflow fixup
module frac_rne_round
   import frac_prod_normalizer_pkg::*;
#(
   parameter int FRAC_W = FRAC_W_DEF,
   parameter int CNT_W = 4
) (
   input  logic [2*FRAC_W-1:0] preg,
   input  logic [CNT_W-1:0]    cnt,
   output logic [FRAC_W-1:0]   mant,
   output logic [CNT_W-1:0]    shift_cnt,
   output logic                inexact
);
   logic [FRAC_W-1:0] m;
   logic g, s, inc, ovf;
   assign m   = preg[2*FRAC_W-1:FRAC_W];
   assign g   = preg[FRAC_W-1];
   assign s   = |preg[FRAC_W-2:0];
   assign inc = g & (s | m[0]);
   assign ovf = inc & (&m);
   // overflow renormalizes by one place when a shift can be undone, otherwise saturates
   always_comb begin
      mant      = ovf ? ((cnt != '0) ? {1'b1, {(FRAC_W-1){1'b0}}} : '1) : m + FRAC_W'(inc);
      shift_cnt = (ovf && cnt != '0) ? cnt - CNT_W'(1) : cnt;
      inexact   = g | s;
   end
endmodule

// File: rtl/frac_prod_normalizer.sv
// frac_prod_normalizer: iterative left-normalize and RNE-round a fractional product
module frac_prod_normalizer
   import frac_prod_normalizer_pkg::*;
#(
   parameter int FRAC_W = FRAC_W_DEF,
   parameter int CNT_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [2*FRAC_W-1:0] product,
   output logic                busy,
   output logic                out_valid,
   output logic [FRAC_W-1:0]   mant,
   output logic [CNT_W-1:0]    shift_cnt,
   output logic                zero,
   output logic                inexact
);
   localparam int PW = prod_w(FRAC_W);
   state_t state, next_state;
   logic [PW-1:0] preg;
   logic [CNT_W-1:0] cnt, r_shift;
   logic [FRAC_W-1:0] r_mant;
   logic r_inexact, done;
   assign done = (preg == '0) || preg[PW-1];
   assign busy = (state == NORM);
   frac_rne_round #(.FRAC_W(FRAC_W), .CNT_W(CNT_W)) u_round (
      .preg      (preg),
      .cnt       (cnt),
      .mant      (r_mant),
      .shift_cnt (r_shift),
      .inexact   (r_inexact)
   );
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end
   // accept in IDLE, leave NORM once the product is zero or normalized
   always_comb begin
      next_state = state;
      next_state = (state == IDLE) ? (in_valid ? NORM : IDLE) : (done ? IDLE : NORM);
   end
   // shift datapath and registered result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         preg      <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         mant      <= '0;
         shift_cnt <= '0;
         zero      <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (state == IDLE && in_valid) begin
            preg <= product;
            cnt  <= '0;
         end else if (state == NORM) begin
            if (preg == '0) begin
               zero      <= 1'b1;
               mant      <= '0;
               shift_cnt <= '0;
               inexact   <= 1'b0;
               out_valid <= 1'b1;
            end else if (!preg[PW-1]) begin
               preg <= preg << 1;
               cnt  <= cnt + CNT_W'(1);
            end else begin
               zero      <= 1'b0;
               mant      <= r_mant;
               shift_cnt <= r_shift;
               inexact   <= r_inexact;
               out_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_frac_prod_normalizer.sv
// tb_frac_prod_normalizer: randomized and directed check against an arithmetic reference model
module tb_frac_prod_normalizer;
   localparam int F = 7;
   localparam int PW = 2 * F;
   localparam int CW = 4;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
   logic [PW-1:0] product = '0;
   logic busy, out_valid, zero, inexact;
   logic [F-1:0] mant;
   logic [CW-1:0] shift_cnt;
   int n_vec = 0, n_bad = 0;
   typedef struct {
      int mant;
      int sh;
      int z;
      int inx;
      int lat;
   } exp_t;
   always #5 clk = ~clk;
   frac_prod_normalizer #(.FRAC_W(F), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .product   (product),
      .busy      (busy),
      .out_valid (out_valid),
      .mant      (mant),
      .shift_cnt (shift_cnt),
      .zero      (zero),
      .inexact   (inexact)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   function automatic exp_t model(input int p);
      exp_t e;
      int n, k, q, r, half;
      e.z = 0; e.mant = 0; e.sh = 0; e.inx = 0; e.lat = 1;
      if (p == 0) begin
         e.z = 1;
         return e;
      end
      n = p; k = 0;
      while (n < (1 << (PW - 1))) begin
         n = n * 2;
         k++;
      end
      q = n / (1 << F);
      r = n % (1 << F);
      half = 1 << (F - 1);
      e.inx = (r != 0) ? 1 : 0;
      e.lat = k + 1;
      if (r > half || (r == half && q % 2 == 1)) q++;
      if (q == (1 << F)) begin
         if (k > 0) begin
            q = 1 << (F - 1);
            k--;
         end else q = (1 << F) - 1;
      end
      e.mant = q;
      e.sh = k;
      return e;
   endfunction
   task automatic apply(input logic [PW-1:0] p, input bit intrude);
      exp_t e;
      int n;
      bit seen;
      logic [F-1:0] m_hold;
      e = model(int'(p));
      n = 0;
      seen = 0;
      @(negedge clk);
      in_valid = 1'b1;
      product = p;
      @(negedge clk);
      in_valid = 1'b0;
      product = PW'($urandom);
      check("busy_after_capture", busy, 1);
      while (!seen && n < PW + 4) begin
         if (intrude && n == 2) begin
            in_valid = 1'b1;
            product = 14'h3F01;
         end else in_valid = 1'b0;
         @(negedge clk);
         n++;
         if (out_valid) seen = 1;
      end
      in_valid = 1'b0;
      check("out_valid_seen", seen, 1);
      if (seen) begin
         check("latency", n, e.lat);
         check("mant", mant, e.mant);
         check("shift_cnt", shift_cnt, e.sh);
         check("zero", zero, e.z);
         check("inexact", inexact, e.inx);
         check("busy_at_done", busy, 0);
         m_hold = mant;
         @(negedge clk);
         check("out_valid_single", out_valid, 0);
         check("mant_hold", mant, m_hold);
      end
   endtask
   initial begin
      int hits;
      logic [PW-1:0] rv;
      logic [PW-1:0] dir [8] = '{14'h2000, 14'h0001, 14'h3F01, 14'h20C0,
                                 14'h2040, 14'h1FE0, 14'h0000, 14'h3FFF};
      repeat (2) @(negedge clk);
      check("rst_mant", mant, 0);
      check("rst_shift", shift_cnt, 0);
      check("rst_zero", zero, 0);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      rst = 1'b0;
      foreach (dir[i]) apply(dir[i], 0);
      for (int i = 0; i < 40; i++) begin
         rv = PW'($urandom);
         apply(rv >> $urandom_range(0, PW), 0);
      end
      apply(14'h0001, 1);
      @(negedge clk);
      in_valid = 1'b1;
      product = 14'h0001;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_mant", mant, 0);
      check("midrst_shift", shift_cnt, 0);
      check("midrst_zero", zero, 0);
      check("midrst_inexact", inexact, 0);
      check("midrst_busy", busy, 0);
      check("midrst_out_valid", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      hits = 0;
      repeat (PW + 2) begin
         @(negedge clk);
         if (out_valid) hits++;
      end
      check("no_out_valid_after_rst", hits, 0);
      apply(14'h20C0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
